// File: rtl/video_pkg.sv
// video_pkg: raster window boundaries, fetch phases and the registered strobe bundle
// shared by the video timing sequencer and its address generator.
package video_pkg;

    localparam logic [8:0] H_PAPER_END = 9'd256;
    localparam logic [8:0] H_BLANK_S   = 9'd304;
    localparam logic [8:0] H_BLANK_E   = 9'd399;
    localparam logic [8:0] H_SYNC_S    = 9'd320;
    localparam logic [8:0] H_SYNC_E    = 9'd351;
    localparam logic [8:0] H_INT_S     = 9'd320;
    localparam logic [8:0] H_INT_E     = 9'd383;

    localparam logic [8:0] V_PAPER_END = 9'd192;
    localparam logic [8:0] V_BLANK_S   = 9'd240;
    localparam logic [8:0] V_BLANK_E   = 9'd255;
    localparam logic [8:0] V_SYNC_S    = 9'd240;
    localparam logic [8:0] V_SYNC_E    = 9'd247;
    localparam logic [8:0] V_INT       = 9'd240;

    localparam logic [5:0] FETCH_COLS  = 6'd32;
    localparam logic [2:0] ATTR_BASE   = 3'b110;

    localparam logic [2:0] P_PIX  = 3'd3;
    localparam logic [2:0] P_ATTR = 3'd5;
    localparam logic [2:0] P_LOAD = 3'd7;

    typedef struct packed {
        logic vrd;
        logic pix_ld;
        logic attr_ld;
        logic shift_ld;
        logic paper;
        logic blank;
        logic sync_n;
        logic int_n;
    } strobes_t;

    localparam strobes_t STROBES_RST = strobes_t'(8'b0000_0011);

    function automatic logic in_win(input logic [8:0] x, input logic [8:0] lo,
                                    input logic [8:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/zx_addr_gen.sv
// zx_addr_gen: maps a fetch line and column to the interleaved pixel byte offset
// and the linear attribute byte offset within the screen bank.
module zx_addr_gen
    import video_pkg::*;
(
    input  logic [7:0]  fy_i,
    input  logic [4:0]  fc_i,
    output logic [12:0] pix_addr_o,
    output logic [12:0] attr_addr_o
);

    assign pix_addr_o  = {fy_i[7:6], fy_i[2:0], fy_i[5:3], fc_i};
    assign attr_addr_o = {ATTR_BASE, fy_i[7:3], fc_i};

endmodule

// File: rtl/video_timing.sv
// video_timing: Pentagon raster counters, screen fetch sequencer and
// sync/blank/interrupt/flash decode feeding the pixel output stage.
module video_timing
    import video_pkg::*;
#(
    parameter int H_TOTAL    = 448,
    parameter int V_TOTAL    = 320,
    parameter int FLASH_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] vaddr,
    output logic        vrd,
    output logic        pix_ld,
    output logic        attr_ld,
    output logic        shift_ld,
    output logic        paper,
    output logic        blank,
    output logic        sync_n,
    output logic        int_n,
    output logic        flash,
    output logic [8:0]  hcnt,
    output logic [8:0]  vcnt
);

    localparam logic [5:0] LAST_CELL = 6'(H_TOTAL / 8 - 1);

    logic                  run_q;
    logic [8:0]            hcnt_q, vcnt_q, h_d, v_d, fy;
    logic [FLASH_BITS-1:0] flash_q, flash_d;
    logic [12:0]           vaddr_q, vaddr_d, pix_addr, attr_addr;
    logic [5:0]            fc;
    logic [2:0]            p;
    logic                  h_last, v_last, active, hsync, vsync;
    strobes_t              strb_q, strb_d;

    assign h_last  = hcnt_q == 9'(H_TOTAL - 1);
    assign v_last  = vcnt_q == 9'(V_TOTAL - 1);
    // First edge after reset loads (0,0) itself, so outputs decode next-state counters
    assign h_d     = (!run_q || h_last) ? 9'd0 : hcnt_q + 9'd1;
    assign v_d     = !run_q ? 9'd0 : !h_last ? vcnt_q : v_last ? 9'd0 : vcnt_q + 9'd1;
    assign flash_d = (run_q && h_last && v_last) ? flash_q + FLASH_BITS'(1) : flash_q;

    assign p      = h_d[2:0];
    // The last cell of each line prefetches column 0 of the following line
    assign fc     = (h_d[8:3] == LAST_CELL) ? 6'd0 : h_d[8:3] + 6'd1;
    assign fy     = (fc != 6'd0) ? v_d : (v_d == 9'(V_TOTAL - 1)) ? 9'd0 : v_d + 9'd1;
    assign active = (fc < FETCH_COLS) && (fy < V_PAPER_END);

    zx_addr_gen u_addr (
        .fy_i        (fy[7:0]),
        .fc_i        (fc[4:0]),
        .pix_addr_o  (pix_addr),
        .attr_addr_o (attr_addr)
    );

    always_comb begin
        hsync           = in_win(h_d, H_SYNC_S, H_SYNC_E);
        vsync           = in_win(v_d, V_SYNC_S, V_SYNC_E);
        strb_d.vrd      = active && (p >= P_PIX - 3'd1) && (p <= P_ATTR);
        strb_d.pix_ld   = active && (p == P_PIX);
        strb_d.attr_ld  = active && (p == P_ATTR);
        strb_d.shift_ld = active && (p == P_LOAD);
        strb_d.paper    = (h_d < H_PAPER_END) && (v_d < V_PAPER_END);
        strb_d.blank    = in_win(h_d, H_BLANK_S, H_BLANK_E) || in_win(v_d, V_BLANK_S, V_BLANK_E);
        strb_d.sync_n   = !(hsync ^ vsync);
        strb_d.int_n    = !((v_d == V_INT) && in_win(h_d, H_INT_S, H_INT_E));
        vaddr_d         = !active ? vaddr_q :
                          (p == P_PIX - 3'd1 || p == P_PIX) ? pix_addr :
                          (p == P_ATTR - 3'd1 || p == P_ATTR) ? attr_addr : vaddr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            flash_q <= '0;
            vaddr_q <= '0;
            strb_q  <= STROBES_RST;
        end else begin
            run_q   <= 1'b1;
            hcnt_q  <= h_d;
            vcnt_q  <= v_d;
            flash_q <= flash_d;
            vaddr_q <= vaddr_d;
            strb_q  <= strb_d;
        end
    end

    assign {vrd, pix_ld, attr_ld, shift_ld, paper, blank, sync_n, int_n} = strb_q;
    assign vaddr = vaddr_q;
    assign hcnt  = hcnt_q;
    assign vcnt  = vcnt_q;
    assign flash = flash_q[FLASH_BITS-1];

endmodule
